// File: rtl/ysyx_220053_pkg.sv
// Shared IFU/decoder definitions: FSM states, widths, reset PC, RV opcodes.
package ysyx_220053_pkg;

  localparam int unsigned XLEN_DEFAULT      = 64;
  localparam int unsigned INSTR_W           = 32;
  localparam logic [63:0] DEFAULT_RESET_PC  = 64'h0000_0000_8000_0000;

  // Major opcodes shared with the decoder
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } ifu_state_t;

  // Instruction fetch targets must be word aligned
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_220053_ifu_if.sv
// IFU bus bundle: imem request/response, execute redirect, decoder handoff.
interface ysyx_220053_ifu_if #(
  parameter int unsigned XLEN = ysyx_220053_pkg::XLEN_DEFAULT
);
  import ysyx_220053_pkg::*;

  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [XLEN-1:0]     imem_req_addr;
  logic                imem_resp_valid;
  logic [INSTR_W-1:0]  imem_resp_data;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic                instr_valid;
  logic                instr_ready;
  logic [INSTR_W-1:0]  instr_o;
  logic [XLEN-1:0]     pc_o;
  logic                misalign_o;

  // IFU side
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_o, pc_o, misalign_o,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, instr_ready
  );

  // Memory / execute / decoder side
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_o, pc_o, misalign_o,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/ysyx_220053_ifu_outbuf.sv
// Holding register for the fetched word and its PC towards the decoder.
module ysyx_220053_ifu_outbuf
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_consume,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [XLEN-1:0]    i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [XLEN-1:0]    o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [XLEN-1:0]    r_pc;

  // Flush beats load beats consume; payload only changes on load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: PC owner, single-outstanding imem fetch, redirect and misalign handling.
module ysyx_220053_ifu
  import ysyx_220053_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned XLEN     = XLEN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_220053_ifu_if.master        bus
);

  ifu_state_t         r_state, w_state_nxt;
  logic [XLEN-1:0]    r_pc, w_pc_nxt;
  logic               r_kill, w_kill_nxt;
  logic               r_misalign, w_misalign_nxt;
  logic               w_load, w_consume, w_flush;
  logic               w_req_hs;
  logic               w_redirect_bad;
  logic               w_ob_valid;
  logic [INSTR_W-1:0] w_ob_instr;
  logic [XLEN-1:0]    w_ob_pc;

  // Request is withheld during reset so no handshake can slip through
  assign bus.imem_req_valid = (r_state == S_REQ) && !rst;
  assign bus.imem_req_addr  = r_pc;
  assign w_req_hs           = bus.imem_req_valid && bus.imem_req_ready;
  assign w_redirect_bad     = bus.redirect_valid && !is_aligned(bus.redirect_pc[1:0]);

  // State, PC, kill and sticky misalign registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= XLEN'(RESET_PC);
      r_kill     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // Next state, PC update and output-buffer control
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_kill_nxt     = r_kill;
    w_misalign_nxt = r_misalign;
    w_load         = 1'b0;
    w_consume      = 1'b0;
    w_flush        = 1'b0;

    if (w_redirect_bad) begin
      w_misalign_nxt = 1'b1;
      w_flush        = 1'b1;
      w_state_nxt    = S_ERR;
    end else begin
      if (bus.redirect_valid) begin
        w_pc_nxt = bus.redirect_pc;
      end
      case (r_state)
        S_REQ: begin
          if (w_req_hs) begin
            w_state_nxt = S_WAIT;
            // Request left for the old PC: its response must be dropped
            if (bus.redirect_valid) begin
              w_kill_nxt = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            if (bus.redirect_valid || r_kill) begin
              w_kill_nxt  = 1'b0;
              w_state_nxt = S_REQ;
            end else begin
              w_load      = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end else if (bus.redirect_valid) begin
            w_kill_nxt = 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            w_flush     = 1'b1;
            w_state_nxt = S_REQ;
          end else if (bus.instr_ready) begin
            w_consume   = 1'b1;
            w_pc_nxt    = r_pc + XLEN'(4);
            w_state_nxt = S_REQ;
          end
        end
        S_ERR: begin
          w_state_nxt = S_ERR;
        end
        default: begin
          w_state_nxt = S_ERR;
        end
      endcase
    end
  end

  ysyx_220053_ifu_outbuf #(
    .XLEN (XLEN)
  ) u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_consume (w_consume),
    .i_flush   (w_flush),
    .i_instr   (bus.imem_resp_data),
    .i_pc      (r_pc),
    .o_valid   (w_ob_valid),
    .o_instr   (w_ob_instr),
    .o_pc      (w_ob_pc)
  );

  assign bus.instr_valid = w_ob_valid;
  assign bus.instr_o     = w_ob_instr;
  assign bus.pc_o        = w_ob_pc;
  assign bus.misalign_o  = r_misalign;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Bench for ysyx_220053_ifu: random memory/decoder/redirect traffic against a program-order model.
module tb_ysyx_220053_ifu;
  import ysyx_220053_pkg::*;

  localparam logic [63:0] RPC = DEFAULT_RESET_PC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_220053_ifu_if bus ();
  ysyx_220053_ifu dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory image: every address holds a distinct, address-derived word
  function automatic logic [31:0] word_of(input logic [63:0] a);
    logic [6:0] opc;
    case (a[3:2])
      2'd0:    opc = OPC_OP_IMM;
      2'd1:    opc = OPC_LUI;
      2'd2:    opc = OPC_JAL;
      default: opc = OPC_BRANCH;
    endcase
    return {a[26:2] ^ a[51:27] ^ 25'h1b3c5a7, opc};
  endfunction

  // Stimulus knobs
  int          ready_pct = 100, dec_pct = 100, rd_pct = 0;
  int          dly_min = 1, dly_max = 1;
  logic        want_rst = 1'b1;
  logic        force_rd = 1'b0;
  logic [63:0] force_pc = '0;

  // Reference state: program order and expectations for the next cycle
  logic [63:0] arch_pc = RPC;
  logic        exp_err = 1'b0, exp_iv_low = 1'b0, exp_addr_v = 1'b0, after_rst = 1'b0;
  logic [63:0] exp_addr = '0;
  logic        hold_v = 1'b0, stall_v = 1'b0;
  logic [31:0] hold_instr = '0;
  logic [63:0] hold_pc = '0, stall_addr = '0;
  logic        pend = 1'b0;
  logic [63:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          cyc = 0, first_req_cyc = -1, first_iv_cyc = -1, cons_total = 0;
  logic        last_iv = 1'b0;
  logic [63:0] cons_q[$];
  int          cons_cyc_q[$];

  task automatic step();
    logic rsp, acc, rd, mis, s_iv, s_req;
    logic [63:0] s_addr, s_pc;
    logic [31:0] s_instr;
    @(negedge clk);
    cyc++;
    rst = want_rst;
    bus.imem_req_ready  = ($urandom_range(99) < ready_pct);
    rsp                 = pend && (pend_cnt == 1);
    bus.imem_resp_valid = rsp;
    bus.imem_resp_data  = rsp ? word_of(pend_addr) : $urandom;
    bus.instr_ready     = ($urandom_range(99) < dec_pct);
    if (force_rd) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = force_pc;
      force_rd           = 1'b0;
    end else if ($urandom_range(99) < rd_pct) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = RPC + 64'(4 * $urandom_range(63));
    end else begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = {$urandom, $urandom};
    end
    #1;
    s_iv = bus.instr_valid; s_req = bus.imem_req_valid; s_addr = bus.imem_req_addr;
    s_pc = bus.pc_o; s_instr = bus.instr_o;
    acc = 1'b0;
    if (rst) begin
      chk("req_valid_in_rst", s_req, 0);
    end else begin
      if (after_rst) begin
        chk("rst_instr_valid", s_iv, 0);
        chk("rst_instr_o", s_instr, 0);
        chk("rst_pc_o", s_pc, 0);
        chk("rst_req_valid", s_req, 1);
        chk("rst_req_addr", s_addr, RPC);
      end
      chk("misalign_o", bus.misalign_o, exp_err);
      if (exp_err) begin
        chk("err_req_valid", s_req, 0);
        chk("err_instr_valid", s_iv, 0);
      end
      chk("req_and_instr", s_req & s_iv, 0);
      if (exp_iv_low) chk("iv_after_redirect", s_iv, 0);
      if (exp_addr_v && s_req) chk("addr_after_redirect", s_addr, exp_addr);
      if (hold_v) begin
        chk("hold_valid", s_iv, 1);
        chk("hold_instr", s_instr, hold_instr);
        chk("hold_pc", s_pc, hold_pc);
      end
      if (stall_v) begin
        chk("stall_valid", s_req, 1);
        chk("stall_addr", s_addr, stall_addr);
      end
      if (s_iv) begin
        chk("pc_o", s_pc, arch_pc);
        chk("instr_o", s_instr, word_of(arch_pc));
      end
      acc = s_req & bus.imem_req_ready;
      if (acc) chk("one_outstanding", pend, 0);
      if (first_req_cyc < 0 && s_req) first_req_cyc = cyc;
      if (first_iv_cyc < 0 && s_iv) first_iv_cyc = cyc;
    end
    last_iv = s_iv && !rst;
    rd  = bus.redirect_valid;
    mis = rd && (bus.redirect_pc[1:0] != 2'b00);
    @(posedge clk);
    if (rst) begin
      arch_pc = RPC; pend = 1'b0; exp_err = 1'b0; exp_iv_low = 1'b0;
      exp_addr_v = 1'b0; hold_v = 1'b0; stall_v = 1'b0; after_rst = 1'b1;
    end else begin
      after_rst  = 1'b0;
      exp_iv_low = rd;
      exp_addr_v = rd && !mis;
      exp_addr   = bus.redirect_pc;
      if (mis) exp_err = 1'b1;
      hold_v = s_iv && !bus.instr_ready && !rd;
      hold_instr = s_instr; hold_pc = s_pc;
      stall_v = s_req && !bus.imem_req_ready && !rd;
      stall_addr = s_addr;
      if (rd && !mis) begin
        arch_pc = bus.redirect_pc;
      end else if (s_iv && bus.instr_ready && !rd) begin
        arch_pc = arch_pc + 64'd4;
        cons_q.push_back(s_pc);
        cons_cyc_q.push_back(cyc);
        cons_total++;
      end
      if (rsp) pend = 1'b0;
      else if (pend) pend_cnt--;
      if (acc) begin
        pend      = 1'b1;
        pend_addr = s_addr;
        pend_cnt  = $urandom_range(dly_max, dly_min);
      end
    end
  endtask

  task automatic wait_pend(input string tag);
    int n = 0;
    while (!pend && n < 20) begin step(); n++; end
    chk(tag, pend, 1);
  endtask

  task automatic wait_iv(input string tag);
    int n = 0;
    while (!last_iv && n < 20) begin step(); n++; end
    chk(tag, last_iv, 1);
  endtask

  initial begin
    int base;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
    want_rst = 1'b1;
    step(); step();
    want_rst = 1'b0;

    // Ideal memory and decoder: latency and throughput
    first_req_cyc = -1; first_iv_cyc = -1;
    cons_q.delete(); cons_cyc_q.delete();
    repeat (10) step();
    chk("t1_latency", 64'(first_iv_cyc - first_req_cyc), 2);
    chk("t1_count", 64'(cons_q.size()), 3);
    if (cons_q.size() >= 3) begin
      chk("t1_pc0", cons_q[0], RPC);
      chk("t1_pc1", cons_q[1], RPC + 64'd4);
      chk("t1_pc2", cons_q[2], RPC + 64'd8);
      chk("t1_spacing", 64'(cons_cyc_q[1] - cons_cyc_q[0]), 3);
    end

    // Decoder backpressure
    dec_pct = 0;
    wait_iv("t2_wait_iv");
    repeat (5) step();
    dec_pct = 100;
    repeat (3) step();

    // Redirect while waiting for a response
    dly_min = 3; dly_max = 3;
    wait_pend("t3_wait_pend");
    force_pc = 64'h8000_0100; force_rd = 1'b1;
    cons_q.delete();
    repeat (14) step();
    if (cons_q.size() > 0) chk("t3_first_pc", cons_q[0], 64'h8000_0100);
    else chk("t3_delivered", 64'(cons_q.size()), 1);

    // Redirect in hold together with instr_ready
    dly_min = 1; dly_max = 1; dec_pct = 0;
    wait_iv("t4_wait_iv");
    dec_pct = 100;
    force_pc = 64'h8000_0200; force_rd = 1'b1;
    cons_q.delete();
    repeat (10) step();
    if (cons_q.size() > 0) chk("t4_first_pc", cons_q[0], 64'h8000_0200);
    else chk("t4_delivered", 64'(cons_q.size()), 1);

    // PC wrap at the top of the address space
    force_pc = 64'hFFFF_FFFF_FFFF_FFFC; force_rd = 1'b1;
    cons_q.delete();
    repeat (12) step();
    if (cons_q.size() >= 2) begin
      chk("wrap_pc0", cons_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_pc1", cons_q[1], 64'h0);
    end else chk("wrap_delivered", 64'(cons_q.size()), 2);

    // Random traffic
    ready_pct = 70; dec_pct = 60; rd_pct = 5; dly_min = 1; dly_max = 4;
    base = cons_total;
    repeat (3000) step();
    chk("progress", 64'(cons_total - base > 100), 1);

    // Misaligned redirect, then reset recovery
    rd_pct = 0; ready_pct = 100; dec_pct = 100; dly_min = 1; dly_max = 1;
    force_pc = 64'h8000_0102; force_rd = 1'b1;
    repeat (6) step();
    want_rst = 1'b1; step();
    want_rst = 1'b0;
    cons_q.delete();
    repeat (8) step();
    if (cons_q.size() > 0) chk("t5_resume_pc", cons_q[0], RPC);
    else chk("t5_delivered", 64'(cons_q.size()), 1);

    // Memory not ready, then reset while waiting
    ready_pct = 0;
    repeat (5) step();
    ready_pct = 100; dly_min = 3; dly_max = 3;
    wait_pend("t6_wait_pend");
    want_rst = 1'b1; step();
    want_rst = 1'b0;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
